// File: rtl/coin_pkg.sv
// ---------------------------------------------------------------------------
// coin_pkg
// Shared definitions for the coin acceptor and the vending FSM that consumes
// its coin code.
//   coin_code_t   : 2-bit coin code (COIN_NONE / COIN_25 / COIN_50)
//   acc_state_t   : acceptor FSM state encoding
//   classify_width: maps a measured pulse width onto a coin code
// ---------------------------------------------------------------------------
package coin_pkg;

  typedef logic [1:0] coin_code_t;

  localparam coin_code_t COIN_NONE = 2'b00;
  localparam coin_code_t COIN_25   = 2'b01;
  localparam coin_code_t COIN_50   = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEASURE = 2'b01,
    GAP     = 2'b10,
    STUCK   = 2'b11
  } acc_state_t;

  // Inclusive window match; anything outside both windows is COIN_NONE,
  // which the caller turns into a reject.
  function automatic coin_code_t classify_width(
    input int unsigned width,
    input int unsigned min25,
    input int unsigned max25,
    input int unsigned min50,
    input int unsigned max50
  );
    coin_code_t code;
    if ((width >= min25) && (width <= max25)) begin
      code = COIN_25;
    end else if ((width >= min50) && (width <= max50)) begin
      code = COIN_50;
    end else begin
      code = COIN_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// ---------------------------------------------------------------------------
// coin_acceptor_if
// Groups the sensor/controller side signals of the coin acceptor.
//   coin_sense : raw optical sensor, 1 = beam blocked (async to clk)
//   inhibit    : 1 = reject every coin
//   coin       : single-cycle coin code per accepted coin
//   reject     : single-cycle pulse per rejected coin
//   jam        : level, sensor blocked beyond the longest valid coin
// Modports: master = controller/sensor side, slave = acceptor.
// ---------------------------------------------------------------------------
interface coin_acceptor_if;
  import coin_pkg::*;

  logic       coin_sense;
  logic       inhibit;
  coin_code_t coin;
  logic       reject;
  logic       jam;

  modport master (
    output coin_sense,
    output inhibit,
    input  coin,
    input  reject,
    input  jam
  );

  modport slave (
    input  coin_sense,
    input  inhibit,
    output coin,
    output reject,
    output jam
  );

endinterface

// File: rtl/coin_debounce.sv
// ---------------------------------------------------------------------------
// coin_debounce
// Two-flop synchronizer followed by a stability filter. The debounced level
// s_db only changes after the synchronized input has held the opposite value
// for DEB_CYC consecutive cycles; shorter glitches are discarded.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   din   : raw asynchronous input
//   s_db  : registered debounced level (0 after reset)
// ---------------------------------------------------------------------------
module coin_debounce #(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic s_db
);

  localparam int unsigned SW = $clog2(DEB_CYC + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          db_r;
  logic [SW-1:0] stab_r;

  // Synchronizer chain plus stability counter; counter restarts whenever
  // the synchronized input agrees with the current debounced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      db_r    <= 1'b0;
      stab_r  <= {SW{1'b0}};
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (sync2_r != db_r) begin
        if (stab_r == SW'(DEB_CYC - 1)) begin
          db_r   <= sync2_r;
          stab_r <= {SW{1'b0}};
        end else begin
          stab_r <= stab_r + SW'(1);
        end
      end else begin
        stab_r <= {SW{1'b0}};
      end
    end
  end

  assign s_db = db_r;

endmodule

// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
// Coin validator: debounces the coin sensor, measures how long each coin
// blocks the beam, and classifies the pulse as 25, 50 or reject. Outputs a
// one-cycle coin code or reject pulse per coin, flags jams and honours
// inhibit (sampled at pulse start).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : coin_acceptor_if.slave (coin_sense, inhibit, coin, reject, jam)
// ---------------------------------------------------------------------------
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEB_CYC = 4,
  parameter int unsigned MIN25   = 20,
  parameter int unsigned MAX25   = 40,
  parameter int unsigned MIN50   = 60,
  parameter int unsigned MAX50   = 100,
  parameter int unsigned GAP_CYC = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic            clk,
  input  logic            reset,
  coin_acceptor_if.slave  bus
);

  localparam int unsigned          GW      = $clog2(GAP_CYC + 1);
  localparam logic [CNT_W-1:0]     JAM_CNT = CNT_W'(MAX50 + 1);
  localparam logic [GW-1:0]        GAP_END = GW'(GAP_CYC - 1);

  logic             s_db_s;

  acc_state_t       state_r,  state_nxt_s;
  logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
  logic [GW-1:0]    gap_r,    gap_nxt_s;
  logic             inh_l_r,  inh_l_nxt_s;
  logic             dbl_r,    dbl_nxt_s;
  coin_code_t       coin_r,   coin_nxt_s;
  logic             reject_r, reject_nxt_s;
  logic             jam_r,    jam_nxt_s;
  coin_code_t       class_s;

  coin_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (bus.coin_sense),
    .s_db  (s_db_s)
  );

  // Window classification of the width accumulated so far.
  always_comb begin
    class_s = classify_width(32'(cnt_r), MIN25, MAX25, MIN50, MAX50);
  end

  // Next-state, counters, flags and next output values.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    gap_nxt_s    = gap_r;
    inh_l_nxt_s  = inh_l_r;
    dbl_nxt_s    = dbl_r;
    coin_nxt_s   = COIN_NONE;
    reject_nxt_s = 1'b0;
    jam_nxt_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (s_db_s) begin
          state_nxt_s = MEASURE;
          cnt_nxt_s   = CNT_W'(1);
          inh_l_nxt_s = bus.inhibit;
          dbl_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      MEASURE: begin
        if (s_db_s) begin
          // Jam exit fires at MAX50+1, so cnt never wraps.
          if (cnt_r == JAM_CNT) begin
            state_nxt_s  = STUCK;
            reject_nxt_s = 1'b1;
            jam_nxt_s    = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = GAP;
          gap_nxt_s   = {GW{1'b0}};
          if (inh_l_r || dbl_r) begin
            reject_nxt_s = 1'b1;
          end else if (class_s != COIN_NONE) begin
            coin_nxt_s = class_s;
          end else begin
            reject_nxt_s = 1'b1;
          end
        end
      end

      STUCK: begin
        // The reject was already issued on entry; leaving only drops jam.
        if (s_db_s) begin
          jam_nxt_s = 1'b1;
        end else begin
          state_nxt_s = GAP;
          gap_nxt_s   = {GW{1'b0}};
        end
      end

      GAP: begin
        if (s_db_s) begin
          // A coin arriving inside the blanking window is always rejected.
          state_nxt_s = MEASURE;
          cnt_nxt_s   = CNT_W'(1);
          inh_l_nxt_s = bus.inhibit;
          dbl_nxt_s   = 1'b1;
        end else if (gap_r == GAP_END) begin
          state_nxt_s = IDLE;
        end else begin
          gap_nxt_s = gap_r + GW'(1);
        end
      end

      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        gap_nxt_s   = {GW{1'b0}};
        inh_l_nxt_s = 1'b0;
        dbl_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, counter, flag and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      gap_r    <= {GW{1'b0}};
      inh_l_r  <= 1'b0;
      dbl_r    <= 1'b0;
      coin_r   <= COIN_NONE;
      reject_r <= 1'b0;
      jam_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      gap_r    <= gap_nxt_s;
      inh_l_r  <= inh_l_nxt_s;
      dbl_r    <= dbl_nxt_s;
      coin_r   <= coin_nxt_s;
      reject_r <= reject_nxt_s;
      jam_r    <= jam_nxt_s;
    end
  end

  assign bus.coin   = coin_r;
  assign bus.reject = reject_r;
  assign bus.jam    = jam_r;

endmodule
